// File: rtl/pattern_uart_tx.sv
// Dumps the 8-step drum pattern as a framed byte stream: header, one byte per step,
// and a trailing XOR checksum when PATTERN_TX_CHECKSUM_EN is defined.
module pattern_uart_tx #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         STEPS   = 8,
  parameter int         BUSY_TO = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dump,
  input  logic [31:0] pattern,
  input  logic        txready,
  output logic [7:0]  txdata,
  output logic        txclk,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RDY  = 2'd1,
    WAIT_BUSY = 2'd2,
    DONE      = 2'd3
  } state_t;

`ifdef PATTERN_TX_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'(STEPS + 1);
`else
  localparam logic [3:0] LAST_IDX = 4'(STEPS);
`endif
  localparam logic [3:0] TO_LAST = 4'(BUSY_TO - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  to_q, to_d;
  logic [31:0] snap_q, snap_d;
  logic [7:0]  txdata_q, txdata_d;
  logic        txclk_q, txclk_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [7:0]  step_byte [STEPS];
  logic [7:0]  cur_byte;
  logic [2:0]  step_sel;

  // Each step byte carries its own index so the receiver can resynchronise.
  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    assign step_byte[gi] = {1'b0, 3'(gi), snap_q[4*gi +: 4]};
  end

  assign step_sel = 3'(idx_q - 4'd1);

`ifdef PATTERN_TX_CHECKSUM_EN
  logic [7:0] checksum;

  always_comb begin
    checksum = HEADER;
    for (int s = 0; s < STEPS; s++) begin
      checksum = checksum ^ step_byte[s];
    end
  end

  always_comb begin
    cur_byte = HEADER;
    if (idx_q == 4'd0) begin
      cur_byte = HEADER;
    end else if (idx_q <= 4'(STEPS)) begin
      cur_byte = step_byte[step_sel];
    end else begin
      cur_byte = checksum;
    end
  end
`else
  always_comb begin
    cur_byte = HEADER;
    if (idx_q != 4'd0) begin
      cur_byte = step_byte[step_sel];
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    to_d     = to_q;
    snap_d   = snap_q;
    txdata_d = txdata_q;
    txclk_d  = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump) begin
          snap_d  = pattern;
          idx_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (txready) begin
          txdata_d = cur_byte;
          txclk_d  = 1'b1;
          to_d     = 4'd0;
          state_d  = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // A UART that never drops txready still gets its byte counted after the timeout.
        if (!txready || (to_q == TO_LAST)) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = WAIT_RDY;
          end
        end else begin
          to_d = to_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      to_q     <= 4'd0;
      snap_q   <= 32'd0;
      txdata_q <= 8'h00;
      txclk_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      to_q     <= to_d;
      snap_q   <= snap_d;
      txdata_q <= txdata_d;
      txclk_q  <= txclk_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign txdata = txdata_q;
  assign txclk  = txclk_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_pattern_uart_tx.sv
// Directed bench for pattern_uart_tx with a small UART handshake model.
module tb_pattern_uart_tx;

`ifdef PATTERN_TX_CHECKSUM_EN
  localparam int FRAME_LEN = 10;
`else
  localparam int FRAME_LEN = 9;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dump;
  logic [31:0] pattern;
  logic        txready;
  logic [7:0]  txdata;
  logic        txclk;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit auto_mode = 1'b0;
  logic [7:0] bytes [$];
  int strobe_cyc [$];

  logic [7:0] zero_exp [10] = '{8'hA5, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'hA5};
  logic [7:0] ramp_exp [10] = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'hA5};

  pattern_uart_tx dut (
    .clk     (clk),
    .rst     (rst),
    .dump    (dump),
    .pattern (pattern),
    .txready (txready),
    .txdata  (txdata),
    .txclk   (txclk),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (txclk === 1'b1) begin
      bytes.push_back(txdata);
      strobe_cyc.push_back(cyc);
      $display("[TB] byte %0d = %02h at cycle %0d", bytes.size() - 1, txdata, cyc);
    end
    if (done === 1'b1) done_cnt++;
  end

  // UART model: txready drops two cycles after a strobe and stays low for three cycles.
  initial begin
    txready = 1'b1;
    forever begin
      @(negedge clk);
      if (auto_mode && txclk === 1'b1) begin
        @(posedge clk);
        @(posedge clk);
        #1 txready = 1'b0;
        repeat (3) @(posedge clk);
        #1 txready = 1'b1;
      end
    end
  end

  function automatic logic [7:0] exp_byte(input logic [31:0] p, input int k);
    logic [7:0] x;
    if (k == 0) return 8'hA5;
    if (k <= 8) return {1'b0, 3'(k - 1), p[4*(k-1) +: 4]};
    x = 8'hA5;
    for (int s = 0; s < 8; s++) x = x ^ {1'b0, 3'(s), p[4*s +: 4]};
    return x;
  endfunction

  task automatic pulse_dump(input logic [31:0] p);
    @(negedge clk);
    pattern = p;
    dump = 1'b1;
    @(negedge clk);
    dump = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got, output bit busy_ok);
    got = 1'b0;
    busy_ok = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  task automatic check_model(input string name, input logic [31:0] p);
    tests++;
    if (bytes.size() != FRAME_LEN) begin
      fails++;
      $display("FAIL %s frame length: got %0d, expected %0d", name, bytes.size(), FRAME_LEN);
    end
    for (int k = 0; k < FRAME_LEN && k < bytes.size(); k++) begin
      tests++;
      if (bytes[k] !== exp_byte(p, k)) begin
        fails++;
        $display("FAIL %s byte %0d: got %02h, expected %02h", name, k, bytes[k], exp_byte(p, k));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dump = 1'b0;
    pattern = 32'h0;
    repeat (3) @(negedge clk);
    tests++;
    if ({txdata, txclk, busy, done} !== 11'h0) begin
      fails++;
      $display("FAIL reset outputs: got txdata=%02h txclk=%b busy=%b done=%b, expected all zero",
               txdata, txclk, busy, done);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || txclk !== 1'b0) begin
      fails++;
      $display("FAIL idle after reset: got busy=%b txclk=%b, expected 0 0", busy, txclk);
    end
    $display("[TB] test_reset complete");
  endtask

  task automatic test_zero_pattern();
    bit got, busy_ok;
    auto_mode = 1'b1;
    bytes.delete();
    done_cnt = 0;
    pulse_dump(32'h0);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL zero busy after dump: got %b, expected 1", busy);
    end
    wait_done(2000, got, busy_ok);
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL zero done timeout: got no done, expected done pulse");
    end
    tests++;
    if (!busy_ok || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero busy window: got busy_ok=%b busy_at_done=%b, expected 1 0", busy_ok, busy);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (done_cnt != 1 || done !== 1'b0) begin
      fails++;
      $display("FAIL zero done pulse: got count=%0d done=%b, expected 1 0", done_cnt, done);
    end
    tests++;
    if (bytes.size() != FRAME_LEN) begin
      fails++;
      $display("FAIL zero frame length: got %0d, expected %0d", bytes.size(), FRAME_LEN);
    end
    for (int k = 0; k < FRAME_LEN && k < bytes.size(); k++) begin
      tests++;
      if (bytes[k] !== zero_exp[k]) begin
        fails++;
        $display("FAIL zero byte %0d: got %02h, expected %02h", k, bytes[k], zero_exp[k]);
      end
    end
    repeat (8) @(negedge clk);
    $display("[TB] test_zero_pattern complete");
  endtask

  task automatic test_pattern_values();
    bit got, busy_ok;
    auto_mode = 1'b1;
    bytes.delete();
    pulse_dump(32'h0000000F);
    wait_done(2000, got, busy_ok);
    tests++;
    if (bytes.size() < 2 || bytes[1] !== 8'h0F) begin
      fails++;
      $display("FAIL step0 byte: got %02h, expected 0f", (bytes.size() > 1) ? bytes[1] : 8'hxx);
    end
`ifdef PATTERN_TX_CHECKSUM_EN
    tests++;
    if (bytes.size() < 10 || bytes[9] !== 8'hAA) begin
      fails++;
      $display("FAIL checksum 0F: got %02h, expected aa", (bytes.size() > 9) ? bytes[9] : 8'hxx);
    end
`endif
    check_model("pat0F", 32'h0000000F);
    repeat (8) @(negedge clk);
    bytes.delete();
    pulse_dump(32'hF0000000);
    wait_done(2000, got, busy_ok);
    tests++;
    if (bytes.size() < 9 || bytes[8] !== 8'h7F) begin
      fails++;
      $display("FAIL step7 byte: got %02h, expected 7f", (bytes.size() > 8) ? bytes[8] : 8'hxx);
    end
    check_model("patF0", 32'hF0000000);
    repeat (8) @(negedge clk);
    $display("[TB] test_pattern_values complete");
  endtask

  task automatic test_held_high();
    bit got, busy_ok;
    auto_mode = 1'b0;
    repeat (8) @(negedge clk);
    txready = 1'b1;
    bytes.delete();
    strobe_cyc.delete();
    pulse_dump(32'h12345678);
    wait_done(1000, got, busy_ok);
    tests++;
    if (!got || !busy_ok) begin
      fails++;
      $display("FAIL held-high completion: got done=%b busy_ok=%b, expected 1 1", got, busy_ok);
    end
    tests++;
    if (strobe_cyc.size() < 2 || (strobe_cyc[1] - strobe_cyc[0]) != 16) begin
      fails++;
      $display("FAIL held-high strobe spacing: got %0d, expected 16",
               (strobe_cyc.size() > 1) ? strobe_cyc[1] - strobe_cyc[0] : -1);
    end
    check_model("held-high", 32'h12345678);
    repeat (4) @(negedge clk);
    $display("[TB] test_held_high complete");
  endtask

  task automatic test_held_low();
    bit got, busy_ok;
    auto_mode = 1'b0;
    txready = 1'b0;
    bytes.delete();
    pulse_dump(32'h0);
    repeat (20) @(negedge clk);
    tests++;
    if (bytes.size() != 0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL held-low no strobe: got %0d strobes busy=%b, expected 0 1", bytes.size(), busy);
    end
    txready = 1'b1;
    @(negedge clk);
    tests++;
    if (txclk !== 1'b1 || txdata !== 8'hA5) begin
      fails++;
      $display("FAIL held-low first strobe: got txclk=%b txdata=%02h, expected 1 a5", txclk, txdata);
    end
    wait_done(1000, got, busy_ok);
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL held-low completion: got no done, expected done pulse");
    end
    repeat (4) @(negedge clk);
    $display("[TB] test_held_low complete");
  endtask

  task automatic test_back_to_back();
    bit got, busy_ok;
    int n;
    auto_mode = 1'b1;
    bytes.delete();
    done_cnt = 0;
    pulse_dump(32'h76543210);
    n = 0;
    while (bytes.size() < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    pattern = 32'hFFFFFFFF;
    dump = 1'b1;
    @(negedge clk);
    dump = 1'b0;
    wait_done(2000, got, busy_ok);
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL mid-dump completion: got no done, expected done pulse");
    end
    for (int k = 0; k < FRAME_LEN && k < bytes.size(); k++) begin
      tests++;
      if (bytes[k] !== ramp_exp[k]) begin
        fails++;
        $display("FAIL mid-dump byte %0d: got %02h, expected %02h", k, bytes[k], ramp_exp[k]);
      end
    end
    repeat (60) @(negedge clk);
    tests++;
    if (bytes.size() != FRAME_LEN || done_cnt != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL mid-dump single frame: got bytes=%0d dones=%0d busy=%b, expected %0d 1 0",
               bytes.size(), done_cnt, busy, FRAME_LEN);
    end
    $display("[TB] test_back_to_back complete");
  endtask

  task automatic test_reset_mid_frame();
    bit got, busy_ok;
    int n, strobes, dones_before;
    auto_mode = 1'b1;
    bytes.delete();
    pulse_dump(32'h76543210);
    n = 0;
    strobes = 0;
    while (strobes < 5 && n < 500) begin
      @(posedge clk);
      #1;
      if (txclk === 1'b1) strobes++;
      n++;
    end
    tests++;
    if (strobes != 5) begin
      fails++;
      $display("FAIL reset-mid reach byte 4: got %0d strobes, expected 5", strobes);
    end
    dones_before = done_cnt;
    rst = 1'b1;
    #1;
    tests++;
    if ({txdata, txclk, busy, done} !== 11'h0) begin
      fails++;
      $display("FAIL reset-mid outputs: got txdata=%02h txclk=%b busy=%b done=%b, expected all zero",
               txdata, txclk, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    tests++;
    if (done_cnt != dones_before) begin
      fails++;
      $display("FAIL reset-mid no done: got %0d dones, expected %0d", done_cnt, dones_before);
    end
    bytes.delete();
    pulse_dump(32'h76543210);
    wait_done(2000, got, busy_ok);
    tests++;
    if (!got || bytes.size() == 0 || bytes[0] !== 8'hA5) begin
      fails++;
      $display("FAIL reset-mid restart: got done=%b first=%02h, expected 1 a5",
               got, (bytes.size() > 0) ? bytes[0] : 8'hxx);
    end
    check_model("restart", 32'h76543210);
    $display("[TB] test_reset_mid_frame complete");
  endtask

  initial begin
    test_reset();
    test_zero_pattern();
    test_pattern_values();
    test_held_high();
    test_held_low();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_uart_tx.md
Name: pattern_uart_tx

Overview:
- Reads out the 8-step drum pattern held by the sequence editor and transmits it as a framed byte stream on the UART transmit side (txdata/txclk/txready).
- It is the dump/reader path, counterpart to the edit/write path.
- Sits between the sequence editor's seq_smpl outputs (packed into one bus) and the top-level UART tx ports.
- Frame: header byte, one byte per step, optional checksum byte.

Parameters:
- HEADER, 8'hA5, first byte of every frame.
- STEPS, 8, number of pattern steps sent. The fixed design value is 8, and the index field is 3 bits.
- BUSY_TO, 15, maximum cycles to wait for txready to drop after a strobe before the byte is treated as accepted. Counter is 4 bits wide.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- dump, input, 1, single-cycle request to transmit the current pattern.
- pattern, input, 32, packed steps; step i is pattern[4*i+3:4*i].
- txready, input, 1, UART can accept a byte (high = idle).
- txdata, output, 8, byte presented to the UART.
- txclk, output, 1, one-cycle write strobe qualifying txdata.
- busy, output, 1, frame in progress.
- done, output, 1, one-cycle pulse after the last byte of a frame is accepted.

Behaviour:
- Reset: clk and reset rst as already decided (asynchronous, active-high). On reset: state IDLE; txdata=8'h00, txclk=0, busy=0, done=0; byte index=0, timeout counter=0, snapshot=0.
- All outputs are registered.
- FSM states: IDLE, WAIT_RDY, WAIT_BUSY, DONE.
- IDLE:
  - dump=1 → capture pattern into the snapshot register, byte index=0, busy=1, go to WAIT_RDY.
  - dump=0 → stay in IDLE.
- WAIT_RDY:
  - txready=1 → on the same edge, load txdata with the current byte, set txclk=1, clear the timeout counter, go to WAIT_BUSY.
  - txready=0 → hold; txclk=0.
- WAIT_BUSY:
  - txclk returns to 0 here, so txclk is high for exactly one cycle per byte.
  - txready=0 → byte accepted.
  - txready stays 1 for BUSY_TO consecutive cycles → byte is also treated as accepted.
  - On acceptance: if this was the last byte, go to DONE; otherwise increment the byte index and go to WAIT_RDY.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Byte sequence (index k):
  - k=0: HEADER.
  - k=1..8: {1'b0, step[2:0], snapshot nibble for that step}, where step=k-1.
  - k=9: checksum (only when the optional feature is enabled).
- Checksum: XOR of the header and all step bytes.
- txdata holds its last value between strobes.
- dump while busy or in DONE: ignored, not queued.
- Pattern changes mid-frame: do not affect the frame; only the snapshot is sent.
- Byte index does not wrap; frame length is fixed.
- rst mid-frame: immediate return to the reset values; a partially sent frame is abandoned and no done pulse is produced.

Optional Feature:
- Macro: PATTERN_TX_CHECKSUM_EN.
- Defined: the frame is 10 bytes (header, 8 steps, checksum).
- Undefined: the frame is 9 bytes, no checksum; done follows acceptance of step 7's byte.

Test Plan:
- Reset, then dump with pattern=32'h0, txready toggling low 2 cycles after each strobe → bytes A5,00,10,20,30,40,50,60,70, plus checksum A5 when the feature is enabled; done pulses once; busy is high from the cycle after dump until DONE.
- pattern=32'h0000000F, checksum enabled → step0 byte 0F, checksum AA; pattern=32'hF0000000 → step7 byte 7F.
- txready held high throughout → each byte is advanced after BUSY_TO=15 cycles; exactly 1 txclk pulse per byte; the frame completes.
- txready held low before the first byte for 20 cycles → no txclk pulse until txready rises; the first strobe is on the rising cycle.
- Second dump mid-frame, and pattern changed after the first dump → the frame contains only the original snapshot; no second frame is sent.
- rst asserted during byte 4 → txclk=0, busy=0, done=0 immediately; a following dump restarts from HEADER.
